// File: rtl/cart_pkg.sv
// Shared types and constants for the N64 cartridge AD16 read master.
package cart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALEH,
        ST_ALEL,
        ST_SETTLE,
        ST_RD_LO,
        ST_RD_HI,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam int DEF_ALE_CYC     = 2;
    localparam int DEF_RD_LOW_CYC  = 8;
    localparam int DEF_RD_HIGH_CYC = 2;
    localparam int TMR_W           = 8;

    localparam logic [8:0] PAGE_MASK = 9'h1FF;

    // The cartridge auto-increments only within a 512-byte page.
    function automatic logic page_start(input logic [8:0] addr_lo);
        return (addr_lo & PAGE_MASK) == 9'h000;
    endfunction

endpackage

// File: rtl/cart_read_master_if.sv
// Request/response stream plus cartridge AD16 bus pins of the read master.
interface cart_read_master_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_last;
    logic        rsp_ready;
    logic        busy;
    logic [15:0] cart_ad_o;
    logic        cart_ad_oe;
    logic [15:0] cart_ad_i;
    logic        cart_aleh;
    logic        cart_alel;
    logic        cart_rd;

    modport master (
        input  req_valid, req_addr, req_len, rsp_ready, cart_ad_i,
        output req_ready, rsp_data, rsp_valid, rsp_last, busy,
               cart_ad_o, cart_ad_oe, cart_aleh, cart_alel, cart_rd
    );

    modport slave (
        output req_valid, req_addr, req_len, rsp_ready, cart_ad_i,
        input  req_ready, rsp_data, rsp_valid, rsp_last, busy,
               cart_ad_o, cart_ad_oe, cart_aleh, cart_alel, cart_rd
    );

endinterface

// File: rtl/cart_phase_timer.sv
// Loadable down-counter; done_o is high on the last cycle of a loaded phase.
module cart_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] len_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = len_i - W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/cart_read_master.sv
// Sequences ALEH/ALEL/RD phases on the cartridge AD16 bus to fetch 32-bit word bursts.
module cart_read_master
    import cart_pkg::*;
#(
    parameter int ALE_CYC     = DEF_ALE_CYC,
    parameter int RD_LOW_CYC  = DEF_RD_LOW_CYC,
    parameter int RD_HIGH_CYC = DEF_RD_HIGH_CYC
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cart_read_master_if.master   bus
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [8:0]  remaining_q, remaining_d;
    logic        hw_sel_q, hw_sel_d;
    logic [15:0] hi_q, hi_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_last_q, rsp_last_d;
    logic [15:0] ad_o_q, ad_o_d;
    logic        oe_q, oe_d;
    logic        aleh_q, aleh_d;
    logic        alel_q, alel_d;
    logic        rd_q, rd_d;

    logic             tmr_done;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_len;
    logic             out_busy;
    state_e           next_word_state;

    function automatic logic [TMR_W-1:0] phase_len(input state_e s);
        case (s)
            ST_ALEH, ST_ALEL, ST_SETTLE: return TMR_W'(ALE_CYC);
            ST_RD_LO:                    return TMR_W'(RD_LOW_CYC);
            ST_RD_HI, ST_DONE:           return TMR_W'(RD_HIGH_CYC);
            default:                     return TMR_W'(1);
        endcase
    endfunction

    // Every state change restarts the shared timer with the new phase length.
    assign tmr_load = (state_d != state_q);
    assign tmr_len  = phase_len(state_d);

    cart_phase_timer #(.W(TMR_W)) u_timer (
        .clk    (clk),
        .rst_n  (reset_n),
        .load_i (tmr_load),
        .len_i  (tmr_len),
        .done_o (tmr_done)
    );

    assign out_busy        = rsp_valid_q && !bus.rsp_ready;
    assign next_word_state = page_start(addr_q[8:0]) ? ST_ALEH : ST_RD_LO;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        hw_sel_d    = hw_sel_q;
        hi_d        = hi_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;

        if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d      = bus.req_addr & 32'hFFFF_FFFC;
                    remaining_d = {1'b0, bus.req_len} + 9'd1;
                    hw_sel_d    = 1'b0;
                    state_d     = ST_ALEH;
                end
            end
            ST_ALEH:   if (tmr_done) state_d = ST_ALEL;
            ST_ALEL:   if (tmr_done) state_d = ST_SETTLE;
            ST_SETTLE: if (tmr_done) state_d = ST_RD_LO;
            ST_RD_LO: begin
                if (tmr_done) begin
                    // Big-endian: the first halfword on the bus is the upper half.
                    if (!hw_sel_q) begin
                        hi_d     = bus.cart_ad_i;
                        hw_sel_d = 1'b1;
                    end else begin
                        rsp_data_d  = {hi_q, bus.cart_ad_i};
                        rsp_valid_d = 1'b1;
                        rsp_last_d  = (remaining_q == 9'd1);
                        addr_d      = addr_q + 32'd4;
                        remaining_d = remaining_q - 9'd1;
                        hw_sel_d    = 1'b0;
                    end
                    state_d = ST_RD_HI;
                end
            end
            ST_RD_HI: begin
                if (tmr_done) begin
                    if (hw_sel_q)               state_d = ST_RD_LO;
                    else if (remaining_q == '0) state_d = ST_DONE;
                    else if (out_busy)          state_d = ST_WAIT;
                    else                        state_d = next_word_state;
                end
            end
            ST_WAIT:   if (!out_busy) state_d = next_word_state;
            ST_DONE:   if (tmr_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so every pin comes straight from a flop.
        aleh_d = 1'b0;
        alel_d = 1'b0;
        oe_d   = 1'b0;
        rd_d   = 1'b1;
        ad_o_d = '0;
        case (state_d)
            ST_ALEH: begin
                aleh_d = 1'b1;
                alel_d = 1'b1;
                oe_d   = 1'b1;
                ad_o_d = addr_d[31:16];
            end
            ST_ALEL: begin
                alel_d = 1'b1;
                oe_d   = 1'b1;
                ad_o_d = addr_d[15:0];
            end
            ST_RD_LO: rd_d = 1'b0;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            hw_sel_q    <= 1'b0;
            hi_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            ad_o_q      <= '0;
            oe_q        <= 1'b0;
            aleh_q      <= 1'b0;
            alel_q      <= 1'b0;
            rd_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            hw_sel_q    <= hw_sel_d;
            hi_q        <= hi_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            ad_o_q      <= ad_o_d;
            oe_q        <= oe_d;
            aleh_q      <= aleh_d;
            alel_q      <= alel_d;
            rd_q        <= rd_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_last   = rsp_last_q;
    assign bus.cart_ad_o  = ad_o_q;
    assign bus.cart_ad_oe = oe_q;
    assign bus.cart_aleh  = aleh_q;
    assign bus.cart_alel  = alel_q;
    assign bus.cart_rd    = rd_q;

endmodule

// File: tb/tb_cart_read_master.sv
// Directed bench: cartridge halfword model, bus capture monitor and a word-level response model.
module tb_cart_read_master;

    localparam int A = 2;
    localparam int L = 8;
    localparam int H = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cart_read_master_if bus();

    cart_read_master #(.ALE_CYC(A), .RD_LOW_CYC(L), .RD_HIGH_CYC(H)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endfunction

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          t;
    } exp_t;

    exp_t        exp_q[$];
    int          arr_q[$];
    logic [31:0] got_q[$];
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [15:0] hw_tab[16];
    int          hw_cnt   = 0;
    int          hw_base  = 0;
    int          rd_falls = 0;
    int          last_k   = 0;

    // Cartridge model and capture path: drive a new halfword on each RD fall, capture on RD rise.
    logic        rd_prev = 1'b1;
    logic        alel_prev = 1'b0;
    logic        hw_half = 1'b0;
    logic [15:0] a_hi = '0, a_lo = '0, d_hi = '0;
    int          mon_idx;
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_prev   = 1'b1;
            alel_prev = 1'b0;
            hw_half   = 1'b0;
        end else begin
            if (rd_prev && !bus.cart_rd) begin
                mon_idx = hw_cnt - hw_base;
                bus.cart_ad_i = (mon_idx >= 0 && mon_idx < 16) ? hw_tab[mon_idx] : 16'hDEAD;
                hw_cnt++;
                rd_falls++;
            end
            if (!rd_prev && bus.cart_rd) begin
                if (!hw_half) d_hi = bus.cart_ad_i;
                else          cap_data.push_back({d_hi, bus.cart_ad_i});
                hw_half = !hw_half;
            end
            if (bus.cart_aleh && bus.cart_alel && bus.cart_ad_oe)  a_hi = bus.cart_ad_o;
            if (!bus.cart_aleh && bus.cart_alel && bus.cart_ad_oe) a_lo = bus.cart_ad_o;
            if (alel_prev && !bus.cart_alel) cap_addr.push_back({a_hi, a_lo});
            rd_prev   = bus.cart_rd;
            alel_prev = bus.cart_alel;
        end
    end

    // Response checker against the expected-word queue.
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [31:0] prev_d = '0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            chk("busy_vs_ready", 32'(bus.busy), 32'(!bus.req_ready));
            if (bus.rsp_valid) begin
                if (prev_v && !prev_r) begin
                    chk("rsp_hold", bus.rsp_data, prev_d);
                end else begin
                    arr_q.push_back(cyc + 1);
                    if (exp_q.size() == 0)   chk("rsp_extra_word", 32'(exp_q.size()), 32'd1);
                    else if (exp_q[0].t >= 0) chk("rsp_time", 32'(cyc + 1), 32'(exp_q[0].t));
                end
                if (bus.rsp_ready && exp_q.size() > 0) begin
                    chk("rsp_data", bus.rsp_data, exp_q[0].d);
                    chk("rsp_last", 32'(bus.rsp_last), 32'(exp_q[0].l));
                    got_q.push_back(bus.rsp_data);
                    void'(exp_q.pop_front());
                end
            end
            prev_v = bus.rsp_valid;
            prev_r = bus.rsp_ready;
            prev_d = bus.rsp_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_scoreboard();
        cap_addr.delete();
        cap_data.delete();
        arr_q.delete();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input bit bp, input string tag);
        int          n, t, f0, fb, stall, guard;
        logic [31:0] wa;
        logic [31:0] exp_addr[$];
        n = int'(len) + 1;
        clear_scoreboard();
        hw_base = hw_cnt;
        f0 = rd_falls;
        bus.rsp_ready = !bp;
        guard = 0;
        while (!bus.req_ready && guard < 100) begin tick(); guard++; end
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.req_valid = 1'b1;
        tick();
        last_k = cyc;
        bus.req_valid = 1'b0;
        chk({tag, "_accept"}, 32'(bus.req_ready), 32'd0);

        t = last_k + 1 + 3 * A + 2 * L + H;
        for (int i = 0; i < n; i++) begin
            wa = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
            if (i > 0) t += 2 * (L + H) + ((wa[8:0] == 9'd0) ? 3 * A : 0);
            if (i == 0 || wa[8:0] == 9'd0) exp_addr.push_back(wa);
            exp_q.push_back('{d: {hw_tab[2*i], hw_tab[2*i+1]}, l: (i == n - 1), t: (bp && i > 0) ? -1 : t});
        end

        if (bp) begin
            guard = 0;
            while (!bus.rsp_valid && guard < 200) begin tick(); guard++; end
            chk({tag, "_first_valid"}, 32'(bus.rsp_valid), 32'd1);
            fb = rd_falls;
            stall = 0;
            repeat (50) begin
                tick();
                if (!bus.cart_rd) stall++;
            end
            chk({tag, "_rd_low_cycles_in_stall"}, 32'(stall), 32'd0);
            chk({tag, "_rd_pulses_in_stall"}, 32'(rd_falls - fb), 32'd0);
            chk({tag, "_valid_held"}, 32'(bus.rsp_valid), 32'd1);
            bus.rsp_ready = 1'b1;
        end

        guard = 0;
        while (!bus.req_ready && guard < 3000) begin tick(); guard++; end
        chk({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
        repeat (2) tick();
        chk({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_rd_pulses"}, 32'(rd_falls - f0), 32'(2 * n));
        chk({tag, "_cap_words"}, 32'(cap_data.size()), 32'(n));
        for (int i = 0; i < n && i < cap_data.size(); i++)
            chk({tag, "_cap_data"}, cap_data[i], {hw_tab[2*i], hw_tab[2*i+1]});
        chk({tag, "_addr_phases"}, 32'(cap_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++)
            chk({tag, "_cap_addr"}, cap_addr[i], exp_addr[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int guard;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_last",  32'(bus.rsp_last),  32'd0);
        chk("rst_rsp_data",  bus.rsp_data,       32'd0);
        chk("rst_ad_o",      32'(bus.cart_ad_o), 32'd0);
        chk("rst_ad_oe",     32'(bus.cart_ad_oe), 32'd0);
        chk("rst_aleh",      32'(bus.cart_aleh), 32'd0);
        chk("rst_alel",      32'(bus.cart_alel), 32'd0);
        chk("rst_rd",        32'(bus.cart_rd),   32'd1);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        reset_n = 1'b1;
        tick();

        hw_tab[0] = 16'h8037;
        hw_tab[1] = 16'h1240;
        run_burst(32'h1000_0000, 8'd0, 1'b0, "single");
        chk("single_latency", (arr_q.size() > 0) ? 32'(arr_q[0] - last_k) : 32'hFFFF_FFFF, 32'd25);
        chk("single_word",    (got_q.size() > 0) ? got_q[0] : 32'hFFFF_FFFF, 32'h8037_1240);
        chk("single_addr",    (cap_addr.size() > 0) ? cap_addr[0] : 32'hFFFF_FFFF, 32'h1000_0000);

        for (int i = 0; i < 16; i++) hw_tab[i] = 16'(i);
        run_burst(32'h1000_0040, 8'd3, 1'b0, "burst");
        chk("burst_word1", (got_q.size() > 1) ? got_q[1] : 32'hFFFF_FFFF, 32'h0002_0003);
        chk("burst_word3", (got_q.size() > 3) ? got_q[3] : 32'hFFFF_FFFF, 32'h0006_0007);
        chk("burst_gap01", (arr_q.size() > 1) ? 32'(arr_q[1] - arr_q[0]) : 32'hFFFF_FFFF, 32'd20);
        chk("burst_gap23", (arr_q.size() > 3) ? 32'(arr_q[3] - arr_q[2]) : 32'hFFFF_FFFF, 32'd20);

        for (int i = 0; i < 16; i++) hw_tab[i] = 16'hA000 + 16'(i);
        run_burst(32'h1000_01F8, 8'd3, 1'b0, "page");
        chk("page_addr2",  (cap_addr.size() > 1) ? cap_addr[1] : 32'hFFFF_FFFF, 32'h1000_0200);
        chk("page_gap12",  (arr_q.size() > 2) ? 32'(arr_q[2] - arr_q[1]) : 32'hFFFF_FFFF, 32'd26);

        for (int i = 0; i < 16; i++) hw_tab[i] = 16'h5A00 + 16'(i);
        run_burst(32'h1000_0100, 8'd2, 1'b1, "bp");

        for (int i = 0; i < 16; i++) hw_tab[i] = 16'hC000 + 16'(i);
        run_burst(32'hFFFF_FFFA, 8'd2, 1'b0, "wrap");
        chk("wrap_addr0", (cap_addr.size() > 0) ? cap_addr[0] : 32'hFFFF_FFFF, 32'hFFFF_FFF8);
        chk("wrap_addr1", (cap_addr.size() > 1) ? cap_addr[1] : 32'hFFFF_FFFF, 32'h0000_0000);

        // Abort a burst during the RD-low phase of its second word.
        for (int i = 0; i < 16; i++) hw_tab[i] = 16'h7700 + 16'(i);
        clear_scoreboard();
        hw_base = hw_cnt;
        bus.rsp_ready = 1'b1;
        bus.req_addr  = 32'h2000_0000;
        bus.req_len   = 8'd3;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{d: {hw_tab[2*i], hw_tab[2*i+1]}, l: (i == 3), t: -1});
        guard = 0;
        while (got_q.size() < 1 && guard < 200) begin tick(); guard++; end
        chk("rst_mid_word1", (got_q.size() > 0) ? got_q[0] : 32'hFFFF_FFFF, 32'h7700_7701);
        guard = 0;
        while (bus.cart_rd && guard < 50) begin tick(); guard++; end
        chk("rst_mid_in_rd_lo", 32'(bus.cart_rd), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_rd",        32'(bus.cart_rd),    32'd1);
        chk("rst_mid_rsp_valid", 32'(bus.rsp_valid),  32'd0);
        chk("rst_mid_req_ready", 32'(bus.req_ready),  32'd1);
        chk("rst_mid_busy",      32'(bus.busy),       32'd0);
        chk("rst_mid_oe",        32'(bus.cart_ad_oe), 32'd0);
        clear_scoreboard();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) hw_tab[i] = 16'h3300 + 16'(i);
        run_burst(32'h3000_0010, 8'd1, 1'b0, "after_rst");
        chk("after_rst_word1", (got_q.size() > 1) ? got_q[1] : 32'hFFFF_FFFF, 32'h3302_3303);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
